// File: rtl/tune_scheduler_pkg.sv
// tune_scheduler_pkg: shared audio constants, tune identifiers and scheduler helpers
package tune_scheduler_pkg;
  typedef enum logic [1:0] {
    TUNE_None     = 2'd0,
    TUNE_BTN      = 2'd1,
    TUNE_Victory  = 2'd2,
    TUNE_GameOver = 2'd3
  } tune_id_t;
  typedef enum logic [1:0] {IDLE, WAIT_START, PLAYING, GAP} sched_state_t;
  localparam int DEF_MIN_GAP = 1000;
  localparam int DEF_START_TIMEOUT = 4;
  localparam logic [7:0] NOTE_C4 = 8'd60;
  localparam logic [7:0] NOTE_E4 = 8'd64;
  localparam logic [7:0] NOTE_G4 = 8'd67;
  localparam logic [7:0] NOTE_C5 = 8'd72;
  function automatic tune_id_t top_tune(input logic [2:0] p);
    return p[2] ? TUNE_GameOver : p[1] ? TUNE_Victory : p[0] ? TUNE_BTN : TUNE_None;
  endfunction
  function automatic logic [2:0] clear_mask(input tune_id_t t);
    return t == TUNE_GameOver ? 3'b111 : t == TUNE_Victory ? 3'b011 : t == TUNE_BTN ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/tune_scheduler_sched_timer.sv
// tune_scheduler_sched_timer: loadable down-counter that parks at zero
module tune_scheduler_sched_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count;
  // Load wins; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - W'(1);
  assign zero = count == '0;
endmodule

// File: rtl/tune_scheduler.sv
// tune_scheduler: arbitrates tune requests into start strobes for the note player
module tune_scheduler
  import tune_scheduler_pkg::*;
#(
  parameter int MIN_GAP       = DEF_MIN_GAP,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_btn,
  input  logic       req_victory,
  input  logic       req_gameover,
  input  logic       mute,
  input  logic       player_busy,
  output logic       new_tune,
  output logic [1:0] tune_id,
  output logic [2:0] pending,
  output logic       dropped
);
  localparam int TMAX = MIN_GAP > START_TIMEOUT ? MIN_GAP : START_TIMEOUT;
  localparam int TW = TMAX > 2 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] GAP_LOAD = TW'(MIN_GAP > 1 ? MIN_GAP - 1 : 0);
  localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT > 1 ? START_TIMEOUT - 1 : 0);
  sched_state_t state;
  tune_id_t cur, sel;
  logic mute_q, mute_rise, zero, load, issue, to_gap, busy_vic;
  logic [2:0] req, acc, eff;
  logic [TW-1:0] value;
  assign tune_id = cur;
  assign req = {req_gameover, req_victory, req_btn};
  assign mute_rise = mute & ~mute_q;
  assign busy_vic = (state == WAIT_START || state == PLAYING) && (cur == TUNE_Victory || cur == TUNE_GameOver);
  assign acc = mute ? 3'b000 : req & (busy_vic ? 3'b110 : 3'b111);
  assign eff = pending | acc;
  assign sel = top_tune(eff);
  assign issue = !mute && eff != 3'b000 &&
    (state == IDLE || (state == GAP && zero) || (state != IDLE && cur == TUNE_BTN && eff[2:1] != 2'b00));
  assign to_gap = (mute_rise && state != IDLE) || (state == WAIT_START && !player_busy && zero) ||
    (state == PLAYING && !player_busy);
  assign load = issue | to_gap;
  assign value = issue ? START_LOAD : GAP_LOAD;
  tune_scheduler_sched_timer #(.W(TW)) sched_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .zero  (zero)
  );
  // Sequencer: issues start strobes, tracks the current tune and the pending latches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= TUNE_None;
      pending <= 3'b000;
      new_tune <= 1'b0;
      dropped <= 1'b0;
      mute_q <= 1'b0;
    end else begin
      mute_q <= mute;
      new_tune <= issue || (mute_rise && state != IDLE);
      dropped <= mute ? (req != 3'b000 || (mute_rise && pending != 3'b000)) :
        (busy_vic && req_btn) || (issue && (eff & (clear_mask(sel) >> 1)) != 3'b000);
      if (mute_rise) begin
        pending <= 3'b000;
        if (state != IDLE) begin
          cur <= TUNE_None;
          state <= GAP;
        end
      end else if (issue) begin
        cur <= sel;
        pending <= eff & ~clear_mask(sel);
        state <= WAIT_START;
      end else begin
        pending <= eff;
        case (state)
          WAIT_START: state <= player_busy ? PLAYING : zero ? GAP : WAIT_START;
          PLAYING:    state <= player_busy ? PLAYING : GAP;
          GAP:        state <= zero ? IDLE : GAP;
          default:    state <= IDLE;
        endcase
      end
    end
endmodule
